// File: rtl/addsub_accumulator.sv
// addsub_accumulator: 4-bit accumulator driving an external add/sub stage through IDLE/EXEC/RESP; in_* accept ops, add_* link the stage, out_* hand back results, acc/flag_*/ovf_sticky/op_count report status
module addsub_accumulator (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sub,
  input  logic       in_cen,
  input  logic [3:0] in_operand,
  input  logic       clr,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_m,
  output logic       add_cen,
  input  logic [3:0] add_s,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] acc,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v,
  output logic       ovf_sticky,
  output logic [7:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, nxt;
  logic [3:0] op_r, t;
  logic sub_r, cen_r, v_new;
  always_comb begin
    in_ready = (state == IDLE) && !clr;
    out_valid = state == RESP;
    nxt = state == IDLE ? (in_valid && in_ready ? EXEC : IDLE) :
          state == EXEC ? RESP : (out_ready ? IDLE : RESP);
  end
  assign add_a = acc;
  assign add_b = op_r;
  assign add_m = sub_r;
  assign add_cen = cen_r;
  assign t = op_r ^ {4{sub_r}};
  assign v_new = cen_r && (acc[3] == t[3]) && (add_s[3] != acc[3]);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      op_r <= '0;
      sub_r <= 1'b0;
      cen_r <= 1'b0;
      {flag_c, flag_z, flag_n, flag_v, ovf_sticky} <= '0;
      op_count <= '0;
    end else begin
      state <= nxt;
      if (in_valid && in_ready) begin
        op_r <= in_operand;
        sub_r <= in_sub;
        cen_r <= in_cen;
      end
      if (state == IDLE && clr) begin
        acc <= '0;
        {flag_c, flag_z, flag_n, flag_v, ovf_sticky} <= '0;
      end
      if (state == EXEC) begin
        acc <= add_s;
        flag_c <= add_cout;
        flag_z <= add_s == 4'd0;
        flag_n <= add_s[3];
        flag_v <= v_new;
        ovf_sticky <= ovf_sticky | v_new;
      end
      if (out_valid && out_ready) op_count <= op_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_addsub_accumulator.sv
// tb_addsub_accumulator: directed bench with an arithmetic reference model and per-cycle output comparison
module tb_addsub_accumulator;
  logic clk = 0, reset = 1, in_valid = 0, in_sub = 0, in_cen = 0, clr = 0, out_ready = 0;
  logic [3:0] in_operand = 0;
  logic in_ready, add_m, add_cen, add_cout, out_valid;
  logic flag_c, flag_z, flag_n, flag_v, ovf_sticky;
  logic [3:0] add_a, add_b, add_s, acc, t_s;
  logic [7:0] op_count;
  addsub_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_cen(in_cen), .in_operand(in_operand), .clr(clr), .add_a(add_a), .add_b(add_b),
    .add_m(add_m), .add_cen(add_cen), .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .flag_c(flag_c),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .ovf_sticky(ovf_sticky),
    .op_count(op_count)
  );
  always #5 clk = ~clk;
  always_comb begin
    t_s = add_b ^ {4{add_m}};
    {add_cout, add_s} = add_cen ? {1'b0, add_a} + {1'b0, t_s} + {4'd0, add_m}
                                : {add_a[3] & t_s[3], add_a ^ t_s};
  end
  logic [3:0] m_acc, m_b;
  logic m_c, m_z, m_n, m_v, m_st, m_m, m_ce, e_ir, e_ov;
  logic [7:0] m_cnt, saved;
  int passed = 0, total = 0;
  bit en = 0;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) if (en) begin
    chk("acc", acc, m_acc);
    chk("flag_c", flag_c, m_c);
    chk("flag_z", flag_z, m_z);
    chk("flag_n", flag_n, m_n);
    chk("flag_v", flag_v, m_v);
    chk("ovf_sticky", ovf_sticky, m_st);
    chk("op_count", op_count, m_cnt);
    chk("in_ready", in_ready, e_ir);
    chk("out_valid", out_valid, e_ov);
    chk("add_a", add_a, m_acc);
    chk("add_b", add_b, m_b);
    chk("add_m", add_m, m_m);
    chk("add_cen", add_cen, m_ce);
  end
  task automatic m_reset;
    {m_acc, m_b, m_c, m_z, m_n, m_v, m_st, m_m, m_ce, e_ov} = '0;
    m_cnt = 0;
    e_ir = 1;
  endtask
  task automatic m_exec;
    int a, b, sa, sb, r;
    logic [3:0] t;
    a = m_acc;
    b = m_b;
    sa = $signed(m_acc);
    sb = $signed(m_b);
    t = m_m ? ~m_b : m_b;
    if (m_ce) begin
      r = m_m ? a - b : a + b;
      m_c = m_m ? a >= b : r > 15;
      m_acc = 4'(r);
      r = m_m ? sa - sb : sa + sb;
      m_v = r > 7 || r < -8;
    end else begin
      m_c = m_acc[3] & t[3];
      m_acc = m_acc ^ t;
      m_v = 0;
    end
    m_z = m_acc == 0;
    m_n = m_acc[3];
    m_st = m_st | m_v;
  endtask
  task automatic do_op(input logic sub, input logic cen, input logic [3:0] b,
                       input int hold, input logic noise, input int rst_at);
    @(posedge clk); #1;
    in_valid = 1; in_sub = sub; in_cen = cen; in_operand = b;
    @(posedge clk); #1;
    in_valid = noise; clr = noise; in_operand = ~b; in_sub = ~sub; in_cen = ~cen;
    e_ir = 0; m_b = b; m_m = sub; m_ce = cen;
    if (rst_at == 1) begin
      reset = 1;
      @(posedge clk); #1;
      reset = 0; in_valid = 0; clr = 0; m_reset;
      return;
    end
    @(posedge clk); #1;
    m_exec;
    e_ov = 1;
    out_ready = hold == 0 && rst_at == 0;
    if (rst_at == 2) begin
      reset = 1;
      @(posedge clk); #1;
      reset = 0; in_valid = 0; clr = 0; m_reset;
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    in_valid = 0; clr = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; e_ov = 0; e_ir = 1; m_cnt++;
  endtask
  task automatic do_clr(input logic vld);
    @(posedge clk); #1;
    clr = 1; in_valid = vld; in_operand = 4'h9; e_ir = 0;
    @(posedge clk); #1;
    clr = 0; in_valid = 0; e_ir = 1;
    {m_acc, m_c, m_z, m_n, m_v, m_st} = '0;
  endtask
  initial begin
    @(posedge clk); #1;
    m_reset;
    en = 1;
    @(posedge clk); #1;
    reset = 0;
    do_op(0, 1, 4'd3, 0, 0, 0);
    do_op(0, 1, 4'd4, 0, 0, 0);
    chk("pin_acc7", acc, 8'h7);
    chk("pin_flags7", {flag_c, flag_z, flag_n, flag_v}, 8'h0);
    chk("pin_cnt2", op_count, 8'd2);
    do_op(0, 1, 4'd1, 0, 0, 0);
    chk("pin_acc8", acc, 8'h8);
    chk("pin_flags8", {flag_c, flag_z, flag_n, flag_v}, 8'b0011);
    chk("pin_sticky8", ovf_sticky, 8'd1);
    do_clr(1);
    chk("pin_clr_acc", acc, 8'h0);
    chk("pin_clr_sticky", ovf_sticky, 8'd0);
    chk("pin_clr_cnt", op_count, 8'd3);
    do_op(0, 1, 4'd5, 0, 0, 0);
    do_op(1, 1, 4'd5, 0, 0, 0);
    chk("pin_sub55", {acc, flag_c, flag_z, flag_n, flag_v}, 8'b0000_1100);
    do_clr(0);
    do_op(0, 1, 4'd2, 0, 0, 0);
    do_op(1, 1, 4'd3, 0, 0, 0);
    chk("pin_sub23", {acc, flag_c, flag_z, flag_n, flag_v}, 8'b1111_0010);
    do_clr(0);
    do_op(0, 1, 4'd5, 0, 0, 0);
    do_op(0, 0, 4'd3, 5, 1, 0);
    chk("pin_xor53", {acc, flag_c, flag_z, flag_n, flag_v}, 8'b0110_0000);
    do_op(1, 0, 4'd2, 0, 1, 0);
    chk("pin_xor_sub", acc, 8'hB);
    saved = m_cnt;
    for (int i = 0; i < 256; i++) do_op(i[0], i[1] | i[2], 4'(i * 7), i % 3, i[3], 0);
    chk("pin_wrap", op_count, saved);
    do_op(0, 1, 4'd6, 0, 0, 1);
    chk("pin_rst_exec_cnt", op_count, 8'd0);
    do_op(0, 1, 4'd3, 0, 0, 0);
    chk("pin_after_rst", {acc, op_count[3:0]}, 8'h31);
    do_op(0, 1, 4'd2, 2, 0, 2);
    chk("pin_rst_resp", {acc, out_valid, 3'd0}, 8'h00);
    chk("pin_rst_resp_cnt", op_count, 8'd0);
    @(posedge clk); #1;
    en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 Parameter: none; datapath width SHALL be fixed at 4 bits to match the four-bit adder/subtracter stage it drives.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 in_sub  input  1  operation select; 0 = add, 1 = subtract (drives adder M).
REQ-007 in_cen  input  1  carry-chain enable for the operation (drives adder Cen).
REQ-008 in_operand  input  4  B operand.
REQ-009 clr  input  1  synchronous clear of accumulator and sticky flag.
REQ-010 add_a, add_b  output  4 each  A and B to the adder/subtracter stage.
REQ-011 add_m, add_cen  output  1 each  M and Cen to the adder/subtracter stage.
REQ-012 add_s  input  4; add_cout  input  1  combinational result from the adder/subtracter stage.
REQ-013 out_valid  input-side handshake: output  1  result available.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 acc  output  4  accumulator value.
REQ-016 flag_c, flag_z, flag_n, flag_v  output  1 each  carry, zero, negative, signed overflow of last operation.
REQ-017 ovf_sticky  output  1  OR of flag_v since last reset/clr.
REQ-018 op_count  output  8  number of completed result handshakes.

Function
REQ-019 FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-020 in_ready SHALL equal (state == IDLE) and not clr.
REQ-021 IDLE -> EXEC when in_valid and in_ready; in_sub, in_cen, in_operand SHALL be registered on that edge.
REQ-022 EXEC SHALL last exactly one cycle; add_a = acc, add_b = registered operand, add_m = registered sub, add_cen = registered cen.
REQ-023 At the EXEC -> RESP edge: acc <= add_s; flag_c <= add_cout; flag_z <= (add_s == 0); flag_n <= add_s[3].
REQ-024 flag_v SHALL be (A[3] == T[3]) and (S[3] != A[3]), T = B XOR {4{M}}, when cen = 1; flag_v SHALL be 0 when cen = 0.
REQ-025 ovf_sticky SHALL set on the EXEC -> RESP edge when the new flag_v is 1, and stay set until reset or clr.
REQ-026 RESP: out_valid = 1; acc and flags SHALL hold stable until out_ready = 1.
REQ-027 RESP -> IDLE on out_valid and out_ready; op_count increments by 1 on that edge, wrapping 255 -> 0.
REQ-028 out_valid SHALL be 0 in IDLE and EXEC; accept-to-out_valid latency SHALL be 2 cycles minimum.
REQ-029 Outside EXEC, add_a/add_b/add_m/add_cen SHALL still drive acc, registered operand, registered sub and registered cen (no X).
REQ-030 clr SHALL act only in IDLE: acc <= 0, ovf_sticky <= 0, flags <= 0; op_count unaffected; clr in EXEC/RESP SHALL be ignored.
REQ-031 clr and in_valid in the same IDLE cycle: clr wins, operation not accepted (in_ready = 0).
REQ-032 Subtract carry convention: flag_c = 1 means no borrow (A >= B unsigned) when cen = 1.

Reset
REQ-033 reset SHALL have priority over clr and all handshakes, in any state.
REQ-034 On reset: state = IDLE; acc = 0; registered operand = 0, sub = 0, cen = 0; all flags = 0; ovf_sticky = 0; op_count = 0; out_valid = 0; in_ready = 1 in the following cycle (clr low).
REQ-035 Reset asserted in EXEC or RESP SHALL discard the operation without updating op_count.

Verification
REQ-036 After reset, add 3 (cen=1) then add 4 -> acc=7, c=0, z=0, n=0, v=0; op_count=2.
REQ-037 acc=7, add 1 (cen=1) -> acc=8, n=1, v=1, c=0, ovf_sticky=1; then clr -> acc=0, ovf_sticky=0.
REQ-038 acc=5, subtract 5 (cen=1) -> acc=0, z=1, c=1, v=0; acc=2, subtract 3 -> acc=F, n=1, c=0, v=0.
REQ-039 acc=5, add 3 with cen=0 -> acc=6 (bitwise XOR, no carry chain), v=0, c = add_cout from stage.
REQ-040 Hold out_ready=0 for 5 cycles in RESP -> out_valid, acc, flags stable, in_ready=0; pulse in_valid meanwhile -> not accepted.
REQ-041 Assert reset during RESP with out_ready=0 -> next cycle state IDLE, acc=0, out_valid=0, op_count unchanged at 0 from reset.
